// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Shared constants for the LED running-light controller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam int              LED_W      = 16;
    localparam logic [LED_W-1:0] LED_ALL_ON = 16'hFFFF;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_tick_gen
// Description : Freezable step divider with run-time selectable limit.
// Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit_m1,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // Compare with >= so a drop to a shorter limit fires at once
    assign o_tick = (r_cnt >= i_limit_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_run_ctrl
// Description : Running-light sequencer: start-up hold, stepping, pause, bounce.
// Revision    : 1.0 - initial release
// ============================================================================
module led_run_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int SLOW_DIV   = 50_000_000,
    parameter int FAST_DIV   = 25_000_000,
    parameter int INIT_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speed,
    input  logic             pause,
    input  logic             bounce,
    output logic [LED_W-1:0] led,
    output logic             step,
    output logic [1:0]       state_o
);

    localparam int CNT_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int INIT_W = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;

    localparam logic [CNT_W-1:0]  c_slow_m1   = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0]  c_fast_m1   = CNT_W'(FAST_DIV - 1);
    localparam logic [INIT_W-1:0] c_init_last = INIT_W'(INIT_STEPS - 1);
    localparam logic [LED_W-1:0]  c_led_one   = {{(LED_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state, w_state_nxt;
    logic [LED_W-1:0] r_led, w_led_nxt;
    logic             r_step, w_step_nxt;
    logic [3:0]       r_pos, w_pos_nxt, w_pos_adv;
    logic             r_dir, w_dir_nxt, w_dir_adv;
    logic [INIT_W-1:0] r_init_cnt, w_init_nxt;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_limit_m1;
    logic             w_tick;

    step_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_cnt_en),
        .i_limit_m1 (w_limit_m1),
        .o_tick     (w_tick)
    );

    // Next position/direction; r_dir=1 means moving up
    always_comb begin
        w_pos_adv = r_pos;
        w_dir_adv = r_dir;
        if (!bounce) begin
            w_dir_adv = 1'b1;
            w_pos_adv = (r_pos == 4'd15) ? 4'd0 : r_pos + 4'd1;
        end else if (r_dir) begin
            if (r_pos == 4'd15) begin
                w_dir_adv = 1'b0;
                w_pos_adv = 4'd14;
            end else begin
                w_pos_adv = r_pos + 4'd1;
            end
        end else begin
            if (r_pos == 4'd0) begin
                w_dir_adv = 1'b1;
                w_pos_adv = 4'd1;
            end else begin
                w_pos_adv = r_pos - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_step_nxt  = 1'b0;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_init_nxt  = r_init_cnt;
        w_cnt_en    = 1'b0;
        w_limit_m1  = c_slow_m1;
        case (r_state)
            ST_INIT: begin
                w_cnt_en  = 1'b1;
                w_led_nxt = LED_ALL_ON;
                if (w_tick) begin
                    if (r_init_cnt == c_init_last) begin
                        w_state_nxt = ST_RUN;
                        w_init_nxt  = '0;
                        w_pos_nxt   = 4'd0;
                        w_dir_nxt   = 1'b1;
                        w_led_nxt   = c_led_one;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_init_nxt = r_init_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (speed) w_limit_m1 = c_fast_m1;
                // Pause beats a coincident tick: the divider stays parked at limit-1
                if (pause) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_tick) begin
                        w_pos_nxt  = w_pos_adv;
                        w_dir_nxt  = w_dir_adv;
                        w_led_nxt  = c_led_one << w_pos_adv;
                        w_step_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!pause) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_led_nxt   = LED_ALL_ON;
                w_pos_nxt   = 4'd0;
                w_dir_nxt   = 1'b1;
                w_init_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_led      <= LED_ALL_ON;
            r_step     <= 1'b0;
            r_pos      <= 4'd0;
            r_dir      <= 1'b1;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_led      <= w_led_nxt;
            r_step     <= w_step_nxt;
            r_pos      <= w_pos_nxt;
            r_dir      <= w_dir_nxt;
            r_init_cnt <= w_init_nxt;
        end
    end

    assign led     = r_led;
    assign step    = r_step;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_run_ctrl
// Description : Randomised self-checking bench for led_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_run_ctrl;

    localparam int SLOW_DIV   = 4;
    localparam int FAST_DIV   = 2;
    localparam int INIT_STEPS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        speed = 1'b0;
    logic        pause = 1'b0;
    logic        bounce = 1'b0;
    logic [15:0] led;
    logic        step;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0=INIT 1=RUN 2=HOLD, position and direction as integers
    int          m_mode, m_cnt, m_inits, m_pos, m_dir;
    logic [15:0] m_led;
    logic        m_step;
    logic [1:0]  m_st;

    led_run_ctrl #(
        .SLOW_DIV   (SLOW_DIV),
        .FAST_DIV   (FAST_DIV),
        .INIT_STEPS (INIT_STEPS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .speed   (speed),
        .pause   (pause),
        .bounce  (bounce),
        .led     (led),
        .step    (step),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic model_advance();
        int n;
        if (!bounce) begin
            m_dir = 1;
            m_pos = (m_pos + 1) % 16;
        end else begin
            n = m_pos + m_dir;
            if (n > 15) begin m_dir = -1; n = 14; end
            else if (n < 0) begin m_dir = 1; n = 1; end
            m_pos = n;
        end
    endtask

    // One clock edge: model evaluates the same inputs the DUT sampled
    task automatic clk_cycle();
        int lim;
        bit tk;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_inits = 0; m_pos = 0; m_dir = 1; m_step = 1'b0;
        end else begin
            lim    = (m_mode == 1 && speed) ? FAST_DIV : SLOW_DIV;
            tk     = (m_cnt >= lim - 1);
            m_step = 1'b0;
            case (m_mode)
                0: begin
                    m_cnt = tk ? 0 : m_cnt + 1;
                    if (tk) begin
                        m_inits++;
                        if (m_inits == INIT_STEPS) begin
                            m_mode = 1; m_pos = 0; m_dir = 1; m_step = 1'b1; m_inits = 0;
                        end
                    end
                end
                1: begin
                    if (pause) m_mode = 2;
                    else begin
                        m_cnt = tk ? 0 : m_cnt + 1;
                        if (tk) begin model_advance(); m_step = 1'b1; end
                    end
                end
                default: if (!pause) m_mode = 1;
            endcase
        end
        m_led = (m_mode == 0) ? 16'hFFFF : (16'h0001 << m_pos);
        m_st  = m_mode[1:0];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; speed = 1'b0; pause = 1'b0; bounce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_cycle();
            n_cmp++;
            if (led !== 16'hFFFF || step !== 1'b0 || state_o !== 2'd0) begin
                n_bad++;
                $display("FAIL reset cyc=%0d led=%h/FFFF step=%b/0 st=%0d/0", i, led, step, state_o);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 8; i++) begin
            pause = 1'($urandom_range(0, 1));
            clk_cycle();
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL init cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
        pause = 1'b0;
        n_cmp++;
        if (led !== 16'h0001 || step !== 1'b1 || state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL init_exit led=%h/0001 step=%b/1 st=%0d/1", led, step, state_o);
        end
    endtask

    task automatic test_wrap();
        int steps = 0;
        speed = 1'b0; pause = 1'b0; bounce = 1'b0;
        for (int i = 0; i < 64; i++) begin
            clk_cycle();
            if (step === 1'b1) steps++;
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL wrap cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
        n_cmp++;
        if (steps != 16 || led !== 16'h0001) begin
            n_bad++;
            $display("FAIL wrap_lap steps=%0d/16 led=%h/0001", steps, led);
        end
    endtask

    task automatic test_speed();
        bounce = 1'b0; pause = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 0) speed = ~speed;
            clk_cycle();
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL speed cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
    endtask

    task automatic test_bounce();
        speed = 1'b1; pause = 1'b0; bounce = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i >= 100 && $urandom_range(0, 9) == 0) bounce = ~bounce;
            if (i >= 100) speed = 1'($urandom_range(0, 1));
            clk_cycle();
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL bounce cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
    endtask

    task automatic test_pause();
        int hold_steps = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 15) == 0) speed = ~speed;
            if ($urandom_range(0, 15) == 0) bounce = ~bounce;
            clk_cycle();
            if (state_o === 2'd2 && step === 1'b1) hold_steps++;
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL pause cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
        pause = 1'b0;
        n_cmp++;
        if (hold_steps != 0) begin
            n_bad++;
            $display("FAIL pause_step_in_hold count=%0d/0", hold_steps);
        end
    endtask

    task automatic test_rst_run();
        pause = 1'b0; speed = 1'b0;
        for (int i = 0; i < 10; i++) clk_cycle();
        rst = 1'b1;
        clk_cycle();
        rst = 1'b0;
        n_cmp++;
        if (led !== 16'hFFFF || step !== 1'b0 || state_o !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_run led=%h/FFFF step=%b/0 st=%0d/0", led, step, state_o);
        end
        for (int i = 0; i < 30; i++) begin
            pause = 1'($urandom_range(0, 1)) & (m_mode == 0);
            clk_cycle();
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL replay cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            speed  = 1'($urandom_range(0, 1));
            bounce = ($urandom_range(0, 19) == 0) ? ~bounce : bounce;
            pause  = ($urandom_range(0, 9) == 0) ? ~pause : pause;
            rst    = ($urandom_range(0, 299) == 0);
            clk_cycle();
            n_cmp++;
            if (led !== m_led || step !== m_step || state_o !== m_st) begin
                n_bad++;
                $display("FAIL random cyc=%0d led=%h/%h step=%b/%b st=%0d/%0d", i, led, m_led, step, m_step, state_o, m_st);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_wrap();
        test_speed();
        test_bounce();
        test_pause();
        test_rst_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
